pad_voice_mixer: RTL
====================

PAD_VOICE_MIXER -- requirements
Module: pad_voice_mixer

Interface
REQ-001 SHALL have parameter NUM_PADS, default 4, number of sample voices (1..16).
REQ-002 SHALL have parameter ADDR_W, default 15, sample address width per voice.
REQ-003 SHALL have parameter SAMPLE_W, default 16, signed sample width.
REQ-004 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port tick  in  1  one-cycle sample-rate strobe (44.1 kHz enable).
REQ-007 SHALL have port pad_trig  in  NUM_PADS  level button per voice; rising edge triggers.
REQ-008 SHALL have port seq_trig  in  NUM_PADS  one-cycle sequencer trigger pulse per voice.
REQ-009 SHALL have port mute  in  NUM_PADS  per-voice mute; muted voice advances, contributes 0.
REQ-010 SHALL have port depth  in  NUM_PADS*ADDR_W  packed sample length per voice; voice v at [v*ADDR_W +: ADDR_W].
REQ-011 SHALL have port mem_addr  out  clog2(NUM_PADS)+ADDR_W  {voice index, sample address} to shared sample RAM.
REQ-012 SHALL have port mem_rden  out  1  read strobe; RAM returns mem_q exactly 1 cycle later.
REQ-013 SHALL have port mem_q  in  SAMPLE_W  signed RAM read data.
REQ-014 SHALL have ports playing  out  NUM_PADS (per-voice active), mix_out  out  SAMPLE_W (signed mixed sample), mix_valid  out  1 (one-cycle pulse), busy  out  1 (scan in progress), overrun  out  1 (sticky).

Function
REQ-015 SHALL set per-voice pending flag on pad_trig rising edge (registered previous value) or seq_trig high, any cycle; simultaneous sources = single trigger.
REQ-016 SHALL, on tick while IDLE, start every pending voice with depth != 0: address = 0, playing = 1, pending cleared; includes retrigger of a playing voice (restart at 0).
REQ-017 SHALL clear pending with no playback for depth == 0.
REQ-018 SHALL implement FSM IDLE -> SCAN (NUM_PADS cycles) -> DRAIN (1 cycle) -> FINISH (1 cycle) -> IDLE.
REQ-019 SHALL, in SCAN cycle k (tick cycle t, k = 0..NUM_PADS-1, cycle t+1+k), drive mem_addr = {k, addr_k}, mem_rden = playing[k]; mem_rden = 0 otherwise.
REQ-020 SHALL advance addr_k by 1 after its read; after read of depth-1, clear playing[k] (voice of depth D yields exactly D reads).
REQ-021 SHALL accumulate mem_q in cycle t+2+k only when voice k was read and not muted; accumulator signed, SAMPLE_W+clog2(NUM_PADS) bits, cleared at tick.
REQ-022 SHALL, in FINISH, saturate accumulator to SAMPLE_W (max 2^(SAMPLE_W-1)-1, min -2^(SAMPLE_W-1)), register into mix_out, pulse mix_valid at cycle t+NUM_PADS+2.
REQ-023 SHALL hold mix_out until next mix_valid; no active voices yields mix_out = 0 with mix_valid.
REQ-024 SHALL assert busy in SCAN, DRAIN, FINISH.
REQ-025 SHALL ignore a tick arriving while busy and set overrun = 1 until reset.
REQ-026 SHALL keep depth sampled at voice start; depth changes mid-play have no effect until next start.
REQ-027 SHALL latch triggers arriving during a scan as pending for next tick.

Reset
REQ-028 SHALL on reset: FSM IDLE, all playing/pending/addresses 0, mix_out = 0, mix_valid = 0, mem_rden = 0, mem_addr = 0, busy = 0, overrun = 0, edge-detect register = 0.
REQ-029 SHALL abort a scan on reset with no mix_valid; accumulated data discarded.

Verification (NUM_PADS=4, ADDR_W=8, SAMPLE_W=16, RAM model returns fixed value)
REQ-030 SHALL check: pad_trig[0] rise, depth0=3, mem_q=0x0100, 5 ticks -> mix_out 0x0100 x3 then 0x0000 x2; mem_addr 0x000,0x001,0x002; mix_valid 6 cycles after each tick.
REQ-031 SHALL check: voices 0,1 triggered, mem_q=0x7000 -> mix_out 0x7FFF; mem_q=0x9000 -> 0x8000.
REQ-032 SHALL check: depth2=10, seq_trig[2] after 4 samples -> next mem_addr for voice 2 = 0x200; mute[2]=1 -> mix_out 0, addresses still advance.
REQ-033 SHALL check: tick 2 cycles after prior tick -> single mix_valid, overrun = 1, stays 1.
REQ-034 SHALL check: reset asserted during SCAN cycle 2 -> no mix_valid, all outputs 0 next cycle; depth1=0 trigger -> playing[1] never high, mem_rden never set for voice 1.

Source files
------------

// File: rtl/pad_voice_mixer.sv
// Multi-voice sample player: scans each playing voice once per sample tick,
// reads one sample per voice from a shared RAM and emits a saturated mix.
module pad_voice_mixer #(
   parameter int NUM_PADS = 4,
   parameter int ADDR_W   = 15,
   parameter int SAMPLE_W = 16
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  tick,
   input  logic [NUM_PADS-1:0]                   pad_trig,
   input  logic [NUM_PADS-1:0]                   seq_trig,
   input  logic [NUM_PADS-1:0]                   mute,
   input  logic [NUM_PADS*ADDR_W-1:0]            depth,
   output logic [$clog2(NUM_PADS)+ADDR_W-1:0]    mem_addr,
   output logic                                  mem_rden,
   input  logic signed [SAMPLE_W-1:0]            mem_q,
   output logic [NUM_PADS-1:0]                   playing,
   output logic signed [SAMPLE_W-1:0]            mix_out,
   output logic                                  mix_valid,
   output logic                                  busy,
   output logic                                  overrun
);

   localparam int VW    = $clog2(NUM_PADS);
   localparam int CNT_W = (VW > 0) ? VW : 1;
   localparam int MA_W  = VW + ADDR_W;
   localparam int ACC_W = SAMPLE_W + VW;

   typedef logic signed [ACC_W-1:0] acc_t;
   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;

   localparam acc_t SAT_MAX = acc_t'((1 << (SAMPLE_W-1)) - 1);
   localparam acc_t SAT_MIN = acc_t'(-(1 << (SAMPLE_W-1)));

   state_t               state;
   logic [CNT_W-1:0]     idx;
   logic [NUM_PADS-1:0]  pad_prev;
   logic [NUM_PADS-1:0]  pending;
   logic [NUM_PADS-1:0]  trig_now;
   logic [NUM_PADS-1:0]  trig_all;
   logic [ADDR_W-1:0]    addr      [NUM_PADS];
   logic [ADDR_W-1:0]    depth_lat [NUM_PADS];
   logic                 rd_pend;
   acc_t                 acc;
   acc_t                 acc_next;
   logic [SAMPLE_W-1:0]  sat_val;

   // NOTE: every variable assigned here gets a default first so no latch is inferred.
   always_comb begin
      trig_now = (pad_trig & ~pad_prev) | seq_trig;
      trig_all = pending | trig_now;
      acc_next = rd_pend ? acc + acc_t'(mem_q) : acc;
      sat_val  = acc_next[SAMPLE_W-1:0];
      if (acc_next > SAT_MAX)
         sat_val = SAT_MAX[SAMPLE_W-1:0];
      else if (acc_next < SAT_MIN)
         sat_val = SAT_MIN[SAMPLE_W-1:0];
   end

   // RAM request is decoded from the scan index so it tracks SCAN cycle k exactly.
   always_comb begin
      mem_addr = '0;
      mem_rden = 1'b0;
      if (state == SCAN) begin
         mem_rden = playing[idx];
         mem_addr = (MA_W'(idx) << ADDR_W) | MA_W'(addr[idx]);
      end
   end

   assign busy = (state != IDLE);

   // NOTE: sequential state uses non-blocking assignments only, so all reads see pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         pad_prev  <= '0;
         pending   <= '0;
         playing   <= '0;
         rd_pend   <= 1'b0;
         acc       <= '0;
         mix_out   <= '0;
         mix_valid <= 1'b0;
         overrun   <= 1'b0;
         // NOTE: the per-voice arrays are small flop banks, so resetting them is cheap and keeps state deterministic.
         for (int v = 0; v < NUM_PADS; v++) begin
            addr[v]      <= '0;
            depth_lat[v] <= '0;
         end
      end else begin
         pad_prev  <= pad_trig;
         pending   <= pending | trig_now;
         mix_valid <= 1'b0;
         if (tick && state != IDLE)
            overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (tick) begin
                  state   <= SCAN;
                  idx     <= '0;
                  acc     <= '0;
                  rd_pend <= 1'b0;
                  pending <= '0;
                  // Zero-depth voices just drop their trigger.
                  for (int v = 0; v < NUM_PADS; v++) begin
                     if (trig_all[v] && depth[v*ADDR_W +: ADDR_W] != '0) begin
                        playing[v]   <= 1'b1;
                        addr[v]      <= '0;
                        depth_lat[v] <= depth[v*ADDR_W +: ADDR_W];
                     end
                  end
               end
            end
            SCAN: begin
               acc     <= acc_next;
               rd_pend <= playing[idx] & ~mute[idx];
               if (playing[idx]) begin
                  addr[idx] <= addr[idx] + ADDR_W'(1);
                  if (addr[idx] == depth_lat[idx] - ADDR_W'(1))
                     playing[idx] <= 1'b0;
               end
               if (idx == CNT_W'(NUM_PADS-1))
                  state <= DRAIN;
               else
                  idx <= idx + CNT_W'(1);
            end
            DRAIN: begin
               // Last voice's data lands now; fold it in and publish the mix.
               acc       <= acc_next;
               rd_pend   <= 1'b0;
               mix_out   <= sat_val;
               mix_valid <= 1'b1;
               state     <= FINISH;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
